// File: rtl/spi_reg_peripheral_pkg.sv
// rtl/spi_reg_peripheral_pkg.sv - shared constants for the SPI register peripheral
//
// Package spi_reg_pkg: register addresses, frame length and the bit
// positions of the R/W, address and data fields within a received frame.
package spi_reg_pkg;

    localparam int FRAME_BITS = 16;

    localparam int ADDR_W = 7;
    localparam int DATA_W = 8;

    // Frame layout, MSB first on the wire: {rw, addr[6:0], data[7:0]}
    localparam int RW_BIT   = 15;
    localparam int ADDR_MSB = 14;
    localparam int ADDR_LSB = 8;
    localparam int DATA_MSB = 7;
    localparam int DATA_LSB = 0;

    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
    localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
    localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;

endpackage

// File: rtl/spi_reg_peripheral_if.sv
// rtl/spi_reg_peripheral_if.sv - SPI pin bundle between controller and register peripheral
//
// Signals: sclk (SPI clock), copi (controller-out data), ncs (active-low select).
// master drives all three pins; slave only observes them.
interface spi_reg_peripheral_if;

    logic sclk;
    logic copi;
    logic ncs;

    modport master (output sclk, output copi, output ncs);
    modport slave  (input  sclk, input  copi, input  ncs);

endinterface

// File: rtl/spi_reg_peripheral_sync_edge_det.sv
// rtl/spi_reg_peripheral_sync_edge_det.sv - multi-flop synchroniser with edge detection
//
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   din        : asynchronous input
//   dout       : synchronised copy of din (STAGES flops deep)
//   rise, fall : one-clk pulses on synchronised rising / falling edges
// IDLE sets the reset value of every flop, so no false edge appears at reset release.
module sync_edge_det #(
    parameter int   STAGES = 2,
    parameter logic IDLE   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              hist_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {STAGES{IDLE}};
            hist_q <= IDLE;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            hist_q <= sync_q[STAGES-1];
        end
    end

    assign dout = sync_q[STAGES-1];
    assign rise = dout & ~hist_q;
    assign fall = ~dout & hist_q;

endmodule

// File: rtl/spi_reg_peripheral.sv
// rtl/spi_reg_peripheral.sv - SPI mode-0 write-only slave holding five PWM control registers
//
// Ports:
//   clk, rst_n        : system clock (>= 8x sclk), asynchronous active-low reset
//   spi (slave)       : sclk / copi / ncs pins, asynchronous to clk
//   en_reg_out_7_0    : register 0x00
//   en_reg_out_15_8   : register 0x01
//   en_reg_pwm_7_0    : register 0x02
//   en_reg_pwm_15_8   : register 0x03
//   pwm_duty_cycle    : register 0x04
//   wr_strobe         : one-clk pulse in the cycle a register is updated
module spi_reg_peripheral #(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = spi_reg_pkg::FRAME_BITS,
    parameter int MAX_ADDR    = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    spi_reg_peripheral_if.slave       spi,
    output logic [7:0]                en_reg_out_7_0,
    output logic [7:0]                en_reg_out_15_8,
    output logic [7:0]                en_reg_pwm_7_0,
    output logic [7:0]                en_reg_pwm_15_8,
    output logic [7:0]                pwm_duty_cycle,
    output logic                      wr_strobe
);

    import spi_reg_pkg::*;

    // Counter must reach FRAME_BITS+1 so an over-long frame stays distinguishable.
    localparam int CNT_W = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic copi_s, copi_rise, copi_fall;
    logic ncs_s,  ncs_rise,  ncs_fall;

    sync_edge_det #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .din(spi.sclk),
        .dout(sclk_s), .rise(sclk_rise), .fall(sclk_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .IDLE(1'b0)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .din(spi.copi),
        .dout(copi_s), .rise(copi_rise), .fall(copi_fall)
    );

    sync_edge_det #(.STAGES(SYNC_STAGES), .IDLE(1'b1)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .din(spi.ncs),
        .dout(ncs_s), .rise(ncs_rise), .fall(ncs_fall)
    );

    // Mode 0 only samples on rising sclk; the remaining edge outputs are not needed.
    logic unused_edges;
    assign unused_edges = &{1'b0, sclk_s, sclk_fall, copi_rise, copi_fall};

    logic [FRAME_BITS-1:0] shift_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  ovf_q;

    logic [ADDR_W-1:0] frame_addr;
    logic [DATA_W-1:0] frame_data;
    logic              commit;

    assign frame_addr = shift_q[ADDR_MSB:ADDR_LSB];
    assign frame_data = shift_q[DATA_MSB:DATA_LSB];

    // Only an exact-length write to an implemented address is accepted.
    assign commit = ncs_rise
                  && (cnt_q == CNT_FULL)
                  && !ovf_q
                  && shift_q[RW_BIT]
                  && (frame_addr <= ADDR_W'(MAX_ADDR));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (ncs_fall) begin
            shift_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (!ncs_s && sclk_rise) begin
            // Gated by the synchronised select, so a bit coinciding with
            // ncs_rise is dropped and idle-bus sclk activity is ignored.
            shift_q <= {shift_q[FRAME_BITS-2:0], copi_s};
            if (cnt_q >= CNT_FULL) begin
                ovf_q <= 1'b1;
            end
            if (cnt_q != CNT_SAT) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_reg_out_7_0  <= 8'h00;
            en_reg_out_15_8 <= 8'h00;
            en_reg_pwm_7_0  <= 8'h00;
            en_reg_pwm_15_8 <= 8'h00;
            pwm_duty_cycle  <= 8'h00;
            wr_strobe       <= 1'b0;
        end else begin
            wr_strobe <= commit;
            if (commit) begin
                case (frame_addr)
                    ADDR_EN_OUT_LO: en_reg_out_7_0  <= frame_data;
                    ADDR_EN_OUT_HI: en_reg_out_15_8 <= frame_data;
                    ADDR_EN_PWM_LO: en_reg_pwm_7_0  <= frame_data;
                    ADDR_EN_PWM_HI: en_reg_pwm_15_8 <= frame_data;
                    ADDR_DUTY:      pwm_duty_cycle  <= frame_data;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_spi_reg_peripheral.sv
// tb/tb_spi_reg_peripheral.sv - self-checking bench for spi_reg_peripheral
module tb_spi_reg_peripheral;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    spi_reg_peripheral_if bus ();

    logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8, pwm_duty_cycle;
    logic       wr_strobe;

    spi_reg_peripheral dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .spi             (bus.slave),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .wr_strobe       (wr_strobe)
    );

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    int strobe_q[$];
    always @(negedge clk) if (wr_strobe !== 1'b0) strobe_q.push_back(cycle);

    logic [7:0] model_regs [5];
    int checks = 0;
    int passes = 0;
    int fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] dut_reg(input int i);
        case (i)
            0: return en_reg_out_7_0;
            1: return en_reg_out_15_8;
            2: return en_reg_pwm_7_0;
            3: return en_reg_pwm_15_8;
            4: return pwm_duty_cycle;
            default: return 8'h00;
        endcase
    endfunction

    task automatic check_regs(input string tag);
        for (int i = 0; i < 5; i++)
            check($sformatf("%s reg%0d", tag, i), 32'(dut_reg(i)), 32'(model_regs[i]));
    endtask

    // A frame is accepted only if it is exactly 16 bits, a write, and addresses 0..4.
    function automatic bit accepts(input logic [31:0] bits, input int nbits);
        int addr;
        addr = int'(bits[14:8]);
        return (nbits == 16) && (bits[15] == 1'b1) && (addr <= 4);
    endfunction

    task automatic model_apply(input logic [31:0] bits, input int nbits);
        if (accepts(bits, nbits)) model_regs[int'(bits[14:8])] = bits[7:0];
    endtask

    task automatic shift_bits(input logic [31:0] bits, input int hi, input int lo, input int half);
        for (int i = hi; i >= lo; i--) begin
            bus.copi = bits[i];
            repeat (half) @(negedge clk);
            bus.sclk = 1'b1;
            repeat (half) @(negedge clk);
            bus.sclk = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] bits, input int nbits, input int half,
                              output int rise_cycle);
        @(negedge clk);
        bus.sclk = 1'b0;
        bus.ncs  = 1'b0;
        repeat (half) @(negedge clk);
        shift_bits(bits, nbits - 1, 0, half);
        repeat (half) @(negedge clk);
        bus.ncs = 1'b1;
        rise_cycle = cycle;
    endtask

    task automatic do_frame(input string tag, input logic [31:0] bits, input int nbits,
                            input int half);
        int rc;
        bit ok;
        strobe_q.delete();
        ok = accepts(bits, nbits);
        send_frame(bits, nbits, half, rc);
        repeat (8) @(negedge clk);
        model_apply(bits, nbits);
        check({tag, " strobes"}, 32'(strobe_q.size()), ok ? 32'd1 : 32'd0);
        if (ok && strobe_q.size() > 0)
            check({tag, " latency"}, 32'(strobe_q[0] - rc), 32'd3);
        check_regs(tag);
    endtask

    int rc1, rc2;

    initial begin
        bus.sclk = 1'b0;
        bus.copi = 1'b0;
        bus.ncs  = 1'b1;
        for (int i = 0; i < 5; i++) model_regs[i] = 8'h00;

        // Reset held with random pin activity
        repeat (20) begin
            @(negedge clk);
            bus.sclk = 1'($urandom);
            bus.ncs  = 1'($urandom);
            bus.copi = 1'($urandom);
            check("reset strobe", 32'(wr_strobe), 32'd0);
        end
        check_regs("in reset");
        @(negedge clk);
        bus.sclk = 1'b0;
        bus.ncs  = 1'b1;
        bus.copi = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        strobe_q.delete();
        repeat (6) @(negedge clk);
        check_regs("after reset");
        check("after reset strobes", 32'(strobe_q.size()), 32'd0);

        // Valid writes
        do_frame("wr0", 32'h80F0, 16, 4);
        do_frame("wr1", 32'h81CC, 16, 4);
        do_frame("wr2", 32'h82AA, 16, 5);
        do_frame("wr3", 32'h8355, 16, 6);
        do_frame("wr4", 32'h8480, 16, 4);

        // Read and out-of-range address
        do_frame("read", 32'h0012, 16, 4);
        do_frame("badaddr", 32'h85FF, 16, 4);

        // Length errors carrying a write of 0xFF to 0x04
        do_frame("short", 32'h84FF >> 1, 15, 4);
        do_frame("long", 32'h84FF << 1, 17, 4);

        // Back-to-back with 4 clk of ncs high
        strobe_q.delete();
        send_frame(32'h8001, 16, 4, rc1);
        repeat (3) @(negedge clk);
        send_frame(32'h8002, 16, 4, rc2);
        repeat (8) @(negedge clk);
        model_apply(32'h8001, 16);
        model_apply(32'h8002, 16);
        check("b2b strobes", 32'(strobe_q.size()), 32'd2);
        if (strobe_q.size() == 2) begin
            check("b2b latency0", 32'(strobe_q[0] - rc1), 32'd3);
            check("b2b latency1", 32'(strobe_q[1] - rc2), 32'd3);
        end
        check_regs("b2b");

        // Reset mid-frame 0x8203, then finish the frame's remaining bits
        strobe_q.delete();
        @(negedge clk);
        bus.ncs = 1'b0;
        repeat (4) @(negedge clk);
        shift_bits(32'h8203, 15, 6, 4);
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) model_regs[i] = 8'h00;
        repeat (3) @(negedge clk);
        check_regs("midreset");
        rst_n = 1'b1;
        shift_bits(32'h8203, 5, 0, 4);
        repeat (4) @(negedge clk);
        bus.ncs = 1'b1;
        repeat (8) @(negedge clk);
        check("midreset strobes", 32'(strobe_q.size()), 32'd0);
        check_regs("midreset after");

        // Timing ratio sclk = clk/8 and clk/32
        do_frame("fast", 32'h8477, 16, 4);
        do_frame("prep", 32'h8400, 16, 4);
        do_frame("slow", 32'h8477, 16, 16);

        // sclk activity with ncs high
        strobe_q.delete();
        repeat (20) begin
            @(negedge clk);
            bus.copi = 1'($urandom);
            repeat (4) @(negedge clk);
            bus.sclk = ~bus.sclk;
        end
        bus.sclk = 1'b0;
        repeat (8) @(negedge clk);
        check("ncs high strobes", 32'(strobe_q.size()), 32'd0);
        check_regs("ncs high");

        // Randomized frames against the model
        for (int n = 0; n < 24; n++) begin
            logic [31:0] f;
            int nb, sel;
            f = 32'($urandom);
            f[14:8] = 7'($urandom_range(0, 7));
            f[15]   = ($urandom_range(0, 3) != 0);
            sel = int'($urandom_range(0, 9));
            nb = (sel == 0) ? 15 : (sel == 1) ? 17 : 16;
            do_frame($sformatf("rand%0d", n), f, nb, int'($urandom_range(4, 12)));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/spi_reg_peripheral.md
Name: spi_reg_peripheral

Overview:
SPI-mode-0 write-only slave that receives configuration frames from an external controller and holds the five 8-bit control registers consumed by the PWM peripheral. It sits directly upstream of pwm_peripheral: its register outputs drive en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8 and pwm_duty_cycle. SPI pins arrive asynchronously on ui_in[0..2] and are synchronised into the clk domain.

Parameters:
SYNC_STAGES, 2, flip-flop depth of each input synchroniser (minimum 2)
FRAME_BITS, 16, bits per valid frame: 1 R/W + 7 address + 8 data
MAX_ADDR, 4, highest writable register address

Ports:
clk  input  1  system clock; must be at least 8x sclk frequency
rst_n  input  1  asynchronous active-low reset
sclk  input  1  SPI clock (ui_in[0]), asynchronous
copi  input  1  SPI data, controller-out peripheral-in (ui_in[1]), asynchronous
ncs  input  1  SPI chip select, active low (ui_in[2]), asynchronous
en_reg_out_7_0  output  8  register 0x00
en_reg_out_15_8  output  8  register 0x01
en_reg_pwm_7_0  output  8  register 0x02
en_reg_pwm_15_8  output  8  register 0x03
pwm_duty_cycle  output  8  register 0x04
wr_strobe  output  1  one-clk pulse in the cycle a register is updated

Behaviour:
- Reset, asynchronous on rst_n low: all five registers = 8'h00; wr_strobe = 0; bit counter = 0; shift register = 0; synchronisers = idle state (sclk 0, ncs 1, copi 0).
- Synchronisation: sclk, copi and ncs each pass through SYNC_STAGES flops, plus one history flop for edge detection. Only synchronised copies are used downstream.
- sclk_rise = sync_sclk & ~hist_sclk. ncs_fall and ncs_rise are derived the same way.
- ncs_fall: clear bit counter and shift register; set the overflow flag to 0.
- While sync_ncs = 0, on each sclk_rise: shift sync_copi in at the LSB, MSB first. Bit counter increments and saturates at FRAME_BITS+1. If the counter was already FRAME_BITS, set overflow.
- sclk falling edges are ignored; the block never drives data out.
- Frame layout: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = data.
- Commit on ncs_rise, only if all of the following hold: counter == FRAME_BITS, overflow = 0, bit15 = 1, address <= MAX_ADDR.
  - On commit, the addressed register takes the data byte at the same clk edge and wr_strobe = 1 for exactly that cycle.
  - Latency: commit is visible SYNC_STAGES+1 clk edges after raw ncs rises (3 edges by default).
- Frames are discarded with no register change and no wr_strobe when any of these hold:
  - fewer than 16 bits received;
  - more than 16 bits received;
  - R/W = 0 (reads are unsupported and silently dropped);
  - address 0x05..0x7F.
- sclk_rise in the same cycle as ncs_rise: the bit is not shifted; the frame is evaluated on the bits already counted.
- sclk activity while sync_ncs = 1 is ignored.
- Reset asserted mid-frame: the partial frame is lost and registers return to 0. After reset deasserts, the first valid frame requires a fresh ncs falling edge.
- Back-to-back frames need at least SYNC_STAGES+2 clk cycles of ncs high between them.
- Registers hold their value indefinitely between commits.

Decomposition:
- Shared package spi_reg_pkg holds:
  - address constants ADDR_EN_OUT_LO=7'h00, ADDR_EN_OUT_HI=7'h01, ADDR_EN_PWM_LO=7'h02, ADDR_EN_PWM_HI=7'h03, ADDR_DUTY=7'h04;
  - FRAME_BITS;
  - field-position constants for R/W, address and data.
- One sub-module: sync_edge_det (SYNC_STAGES-deep synchroniser with rise/fall outputs), instantiated three times.
- Shift/count/commit logic stays in the top module.

Test Plan:
- Reset: hold rst_n low, toggle sclk/ncs randomly -> all five registers read 8'h00 and wr_strobe stays 0; release reset -> values unchanged.
- Valid writes: frames 0x80F0, 0x81CC, 0x82AA, 0x8355, 0x8480 -> registers hold 0xF0, 0xCC, 0xAA, 0x55, 0x80 respectively. wr_strobe pulses once per frame, exactly 3 clk after ncs rises.
- Read and invalid-address frames: 0x0012 and 0x85FF -> no register changes, no wr_strobe.
- Length errors: 15-bit frame and 17-bit frame, each carrying a write of 0xFF to 0x04 -> pwm_duty_cycle keeps its previous value (0x80).
- Back-to-back: 0x8001 then 0x8002 to the same address, separated by 4 clk of ncs high -> en_reg_out_7_0 ends at 0x02 and two wr_strobe pulses are seen. Then reset asserted mid-frame 0x8203 -> en_reg_pwm_7_0 = 0x00 and the frame is not committed.
- Timing ratio: sclk at clk/8 versus clk/32 with frame 0x8477 -> pwm_duty_cycle = 0x77 in both cases. sclk toggled with ncs high -> no effect.
